ksa_sub_seq_48bit: RTL and testbench
====================================

// Module: ksa_sub_seq_48bit
// PURPOSE
//   Sequential 48-bit subtractor: D = A - B - Bi, one CHUNK-bit slice per clock, LSB first, with a registered borrow chain.
//   Inverse-direction companion to the combinational 48-bit chunked KSA adder.
//   Trades 6 cycles of latency for one 8-bit slice datapath.
//   Driven by the top-module controller through a start/busy/done handshake.
// PARAMETERS
//   WIDTH  48  operand/result width; must be a multiple of CHUNK
//   CHUNK  8   bits processed per cycle; NCHUNK = WIDTH/CHUNK (default 6)
// PORTS
//   clk    in   1      single clock, rising edge
//   rst    in   1      synchronous reset, active-high
//   start  in   1      request; sampled only when idle or in the done cycle
//   Bi     in   1      borrow in, latched with start
//   A      in   WIDTH  minuend, latched with start
//   B      in   WIDTH  subtrahend, latched with start
//   busy   out  1      high while slices are being computed
//   done   out  1      one-cycle pulse; D/Bo valid from this cycle on
//   D      out  WIDTH  difference, registered
//   Bo     out  1      borrow out of the MSB slice, registered
// BEHAVIOUR
//   - Reset (rst=1 at edge): state IDLE; busy=0, done=0, D=0, Bo=0, slice index=0, borrow reg=0.
//   - FSM states: IDLE -> RUN (start=1) -> DONE (after last slice) -> IDLE, or -> RUN if start=1 in DONE.
//   - Accept (start=1 at edge k, state IDLE or DONE): latch A, B; borrow reg<=Bi; idx<=0; busy=1, done=0.
//   - RUN, each edge: {b,d} = A[idx slice] - B[idx slice] - borrow, computed CHUNK+1 bits wide.
//     D[idx slice]<=d; borrow<=b; idx<=idx+1.
//   - Slice i is written at edge k+1+i. At edge k+NCHUNK the last slice is written,
//     Bo<=final borrow, done<=1, busy<=0.
//   - Latency: start edge to done high = NCHUNK cycles (6). Throughput: one operation per NCHUNK cycles.
//   - done is high for exactly one cycle. D and Bo hold their value until the next accepted start.
//   - D holds partially updated slices while busy; consumers read D only when done=1 or later.
//   - start while busy: ignored; operands are not re-latched.
//   - start in the DONE cycle: accepted (back-to-back), and done drops the next cycle.
//   - Borrow wrap: an all-ones result with Bo=1 is legal (e.g. 0-1). No saturation.
//   - Reset mid-operation: aborts. All outputs return to reset values at that edge and no done is issued.
//   - Arithmetic is unsigned modulo 2^WIDTH. Bo=1 iff A < B+Bi, treating all three as unsigned.
// CONFIGURATION
//   Macro KSA_SUB_FLAGS_EN.
//   Defined: adds two outputs, updated at the done edge and held with D. Both reset to 0.
//     Z  out 1  set when D == 0.
//     V  out 1  signed two's-complement overflow: A[MSB]!=B[MSB] && D[MSB]!=A[MSB].
//   Undefined: Z and V ports and their logic are absent. All other behaviour is identical.
// TESTING
//   1 A=48'h000000000005, B=48'h3, Bi=0, start pulse -> done exactly 6 cycles later; D=48'h2, Bo=0.
//   2 A=0, B=1, Bi=0 -> D=48'hFFFFFFFFFFFF, Bo=1 (borrow ripples through all 6 slices).
//   3 A=48'h000000000100, B=48'h1, Bi=1 -> D=48'h0000000000FE, Bo=0 (cross-slice borrow).
//   4 start held high continuously with operands changing while busy -> operands re-latched only
//     in the done cycle; results at cycles 6, 12, 18, each matching the operands latched at its start.
//   5 rst=1 during slice 3 -> next cycle busy=0, done=0, D=0, Bo=0; no done pulse appears afterwards.
//   6 (KSA_SUB_FLAGS_EN) A=48'h800000000000, B=1 -> D=48'h7FFFFFFFFFFF, V=1, Z=0, Bo=0;
//     A=B=48'h123456789ABC -> D=0, Z=1, V=0.

Source files
------------

// File: rtl/ksa_sub_seq_48bit.sv
// ksa_sub_seq_48bit: sequential D = A - B - Bi, one CHUNK slice per clock, LSB first.
// Ports: clk, rst (sync, active-high), start/busy/done handshake, Bi/A/B in, D/Bo out.
// Optional KSA_SUB_FLAGS_EN adds Z (D==0) and V (signed overflow), updated with done.
module ksa_sub_seq_48bit #(
  parameter int WIDTH = 48,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Bi,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
`ifdef KSA_SUB_FLAGS_EN
  ,
  output logic             Z,
  output logic             V
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_brw;
  logic [IW-1:0]    r_idx;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_as;
  logic [CHUNK-1:0] w_bs;
  logic [CHUNK:0]   w_diff;
  logic [WIDTH-1:0] w_dnext;

  // start is honoured only when no slice work is pending
  assign w_accept = start &&
    (r_state == S_IDLE || r_state == S_DONE);
  assign w_last = (r_state == S_RUN) &&
    (r_idx == IW'(NCHUNK - 1));

  always_comb begin
    w_as = r_a[r_idx*CHUNK +: CHUNK];
    w_bs = r_b[r_idx*CHUNK +: CHUNK];
    // one extra bit: its MSB is the borrow out of this slice
    w_diff = {1'b0, w_as} - {1'b0, w_bs}
           - {{CHUNK{1'b0}}, r_brw};
    w_dnext = D;
    w_dnext[r_idx*CHUNK +: CHUNK] = w_diff[CHUNK-1:0];
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_brw <= 1'b0;
      r_idx <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      Bo    <= 1'b0;
`ifdef KSA_SUB_FLAGS_EN
      Z     <= 1'b0;
      V     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_brw <= Bi;
      r_idx <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (r_state == S_RUN) begin
      D     <= w_dnext;
      r_brw <= w_diff[CHUNK];
      r_idx <= r_idx + 1'b1;
      if (w_last) begin
        Bo   <= w_diff[CHUNK];
        done <= 1'b1;
        busy <= 1'b0;
`ifdef KSA_SUB_FLAGS_EN
        Z <= (w_dnext == '0);
        V <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
             (w_dnext[WIDTH-1] != r_a[WIDTH-1]);
`endif
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ksa_sub_seq_48bit.sv
// tb_ksa_sub_seq_48bit: directed vectors for the sequential subtractor.
// Hand-computed expected values; one check task; one summary line.
module tb_ksa_sub_seq_48bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        Bi = 1'b0;
  logic [47:0] A = '0;
  logic [47:0] B = '0;
  logic        busy;
  logic        done;
  logic [47:0] D;
  logic        Bo;
`ifdef KSA_SUB_FLAGS_EN
  logic        Z;
  logic        V;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  ksa_sub_seq_48bit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Bi    (Bi),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bo    (Bo)
`ifdef KSA_SUB_FLAGS_EN
    ,
    .Z     (Z),
    .V     (V)
`endif
  );

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // edges after the accept edge until done is seen (13 = never)
  task automatic wait_done(output int n);
    n = 13;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [47:0] a,
                        input logic [47:0] b,
                        input logic bi,
                        input logic [47:0] ed,
                        input logic eb);
    int n;
    @(negedge clk);
    A = a;
    B = b;
    Bi = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, 48'(busy), 48'd1);
    wait_done(n);
    chk({tag, "_lat"}, 48'(n), 48'd6);
    chk({tag, "_D"}, D, ed);
    chk({tag, "_Bo"}, 48'(Bo), 48'(eb));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 48'(done), 48'd0);
    chk({tag, "_hold"}, D, ed);
  endtask

  logic [47:0] ta [3];
  logic [47:0] tb [3];
  logic [47:0] td [3];
  logic        tbo [3];

  initial begin
    int n;
    int ndone;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_done", 48'(done), 48'd0);
    chk("rst_D", D, 48'd0);
    chk("rst_Bo", 48'(Bo), 48'd0);
`ifdef KSA_SUB_FLAGS_EN
    chk("rst_Z", 48'(Z), 48'd0);
    chk("rst_V", 48'(V), 48'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_op("t1", 48'h5, 48'h3, 1'b0,
           48'h2, 1'b0);
    run_op("t2", 48'h0, 48'h1, 1'b0,
           48'hFFFF_FFFF_FFFF, 1'b1);
    run_op("t3", 48'h100, 48'h1, 1'b1,
           48'hFE, 1'b0);
    run_op("eqbi", 48'h5A5A_5A5A_5A5A,
           48'h5A5A_5A5A_5A5A, 1'b1,
           48'hFFFF_FFFF_FFFF, 1'b1);
    run_op("max", 48'hFFFF_FFFF_FFFF, 48'h0,
           1'b0, 48'hFFFF_FFFF_FFFF, 1'b0);
    run_op("big", 48'hABCD_EF01_2345,
           48'h1234_5678_9ABC, 1'b0,
           48'h9999_9888_8889, 1'b0);

    // back-to-back with start held high;
    // junk operands while busy must be ignored
    ta[0] = 48'h1111_1111_1111;
    tb[0] = 48'h0111_1111_1110;
    td[0] = 48'h1000_0000_0001;
    tbo[0] = 1'b0;
    ta[1] = 48'h10;
    tb[1] = 48'h20;
    td[1] = 48'hFFFF_FFFF_FFEF;
    tbo[1] = 1'b1;
    ta[2] = 48'hABCD_EF01_2345;
    tb[2] = 48'h1234_5678_9ABC;
    td[2] = 48'h9999_9888_8889;
    tbo[2] = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      A = ta[k];
      B = tb[k];
      Bi = (k == 1);
      @(posedge clk);
      #1;
      chk("b2b_busy", 48'(busy), 48'd1);
      chk("b2b_drop", 48'(done), 48'd0);
      A = 48'hDEAD_BEEF_CAFE;
      B = 48'h0123_4567_89AB;
      Bi = 1'b0;
      wait_done(n);
      chk("b2b_lat", 48'(n), 48'd6);
      chk("b2b_D", D, td[k]);
      chk("b2b_Bo", 48'(Bo), 48'(tbo[k]));
    end
    start = 1'b0;
    @(posedge clk);
    #1;

    // reset while slice 3 is being computed
    @(negedge clk);
    A = 48'h0;
    B = 48'h1;
    Bi = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 48'(busy), 48'd0);
    chk("abort_done", 48'(done), 48'd0);
    chk("abort_D", D, 48'd0);
    chk("abort_Bo", 48'(Bo), 48'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_nodone", 48'(ndone), 48'd0);

`ifdef KSA_SUB_FLAGS_EN
    run_op("f1", 48'h8000_0000_0000, 48'h1,
           1'b0, 48'h7FFF_FFFF_FFFF, 1'b0);
    chk("f1_V", 48'(V), 48'd1);
    chk("f1_Z", 48'(Z), 48'd0);
    run_op("f2", 48'h1234_5678_9ABC,
           48'h1234_5678_9ABC, 1'b0,
           48'h0, 1'b0);
    chk("f2_Z", 48'(Z), 48'd1);
    chk("f2_V", 48'(V), 48'd0);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
